// File: rtl/uart_pkg.sv
// Shared definitions for the UART command responder: default opcodes,
// response codes and the parser state encoding.
package uart_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h4B;
  localparam logic [7:0] RSP_NAK   = 8'h3F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } resp_state_t;

  // Address register width; a single-register bank still needs one bit.
  function automatic int addr_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/uart_reg_bank.sv
// 8-bit register bank: one synchronous write port, one combinational read
// port, whole bank exposed as a flat vector.
module uart_reg_bank #(
  parameter int NUM_REGS = 8,
  parameter int AW       = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [7:0]            wdata,
  input  logic [AW-1:0]         raddr,
  output logic [7:0]            rdata,
  output logic [8*NUM_REGS-1:0] regs_out
);

  logic [7:0] r_regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else if (we) begin
      r_regs[waddr] <= wdata;
    end
  end

  // Callers only present in-range read addresses.
  assign rdata = r_regs[raddr];

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign regs_out[8*gi +: 8] = r_regs[gi];
    end
  endgenerate

endmodule

// File: rtl/uart_reg_responder.sv
// Packet parser between uart_rx and uart_tx: 'W' addr data writes the bank
// and answers ACK, 'R' addr answers with the register value, errors give NAK.
module uart_reg_responder #(
  parameter int         NUM_REGS       = 8,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] CMD_WRITE      = uart_pkg::CMD_WRITE,
  parameter logic [7:0] CMD_READ       = uart_pkg::CMD_READ,
  parameter logic [7:0] RSP_ACK        = uart_pkg::RSP_ACK,
  parameter logic [7:0] RSP_NAK        = uart_pkg::RSP_NAK
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  rx_error,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  output logic [8*NUM_REGS-1:0] regs_out,
  output logic                  busy
);
  import uart_pkg::*;

  localparam int AW = addr_width(NUM_REGS);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]    NUM_REGS_9  = 9'(NUM_REGS);

  resp_state_t   r_state, w_state_next;
  logic          r_is_write, w_is_write_next;
  logic [AW-1:0] r_addr, w_addr_next;
  logic [7:0]    r_tx_data, w_tx_data_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic          w_we;
  logic [7:0]    w_rdata;
  logic          w_addr_oob;

  // Full 8-bit compare so high address bits are never silently aliased.
  assign w_addr_oob = ({1'b0, rx_data} >= NUM_REGS_9);

  uart_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .we       (w_we),
    .waddr    (r_addr),
    .wdata    (rx_data),
    .raddr    (rx_data[AW-1:0]),
    .rdata    (w_rdata),
    .regs_out (regs_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_tx_data  <= 8'h00;
      r_timer    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_is_write <= w_is_write_next;
      r_addr     <= w_addr_next;
      r_tx_data  <= w_tx_data_next;
      r_timer    <= w_timer_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_is_write_next = r_is_write;
    w_addr_next     = r_addr;
    w_tx_data_next  = r_tx_data;
    w_timer_next    = '0;
    w_we            = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_valid) begin
          if (!rx_error && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
            w_is_write_next = (rx_data == CMD_WRITE);
            w_state_next    = ADDR;
          end else begin
            w_tx_data_next = RSP_NAK;
            w_state_next   = RESP;
          end
        end
      end
      ADDR: begin
        if (rx_valid) begin
          if (rx_error || w_addr_oob) begin
            w_tx_data_next = RSP_NAK;
            w_state_next   = RESP;
          end else if (!r_is_write) begin
            w_tx_data_next = w_rdata;
            w_state_next   = RESP;
          end else begin
            w_addr_next  = rx_data[AW-1:0];
            w_state_next = DATA;
          end
        end else if (r_timer == TIMER_LIMIT) begin
          w_state_next = IDLE;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      DATA: begin
        if (rx_valid) begin
          w_state_next = RESP;
          if (rx_error) begin
            w_tx_data_next = RSP_NAK;
          end else begin
            w_we           = 1'b1;
            w_tx_data_next = RSP_ACK;
          end
        end else if (r_timer == TIMER_LIMIT) begin
          w_state_next = IDLE;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      RESP: begin
        // Bytes arriving while a response is pending are dropped.
        if (tx_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign tx_valid = (r_state == RESP);
  assign tx_data  = r_tx_data;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed bench for uart_reg_responder with an 8-register bank and a
// 50-cycle inter-byte timeout.
module tb_uart_reg_responder;

  localparam int NR = 8;
  localparam int TC = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_error;
  logic          tx_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic [8*NR-1:0] regs_out;
  logic          busy;

  int n_pass  = 0;
  int n_total = 0;
  int n_tx_seen;

  always #5 clk = ~clk;

  uart_reg_responder #(
    .NUM_REGS       (NR),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_error (rx_error),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .regs_out (regs_out),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a falling edge; presents one byte for exactly one rising edge.
  task automatic send(input logic [7:0] b, input logic err);
    rx_valid = 1'b1;
    rx_data  = b;
    rx_error = err;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_error = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic expect_resp(input string tag, input logic [7:0] exp);
    int waited;
    waited = 0;
    while (!tx_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " valid"}, 64'(tx_valid), 64'd1);
    check({tag, " data"}, 64'(tx_data), 64'(exp));
    $display("resp %s: tx_data=%h expected=%h", tag, tx_data, exp);
    if (tx_ready) begin
      @(negedge clk);
      check({tag, " idle"}, 64'({tx_valid, busy}), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_error = 1'b0; tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset tx_valid", 64'(tx_valid), 64'd0);
    check("reset tx_data", 64'(tx_data), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset regs", regs_out, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // write then read back
    send(8'h57, 1'b0); send(8'h02, 1'b0); send(8'hA5, 1'b0);
    expect_resp("write r2", 8'h4B);
    check("reg2 value", 64'(regs_out[23:16]), 64'hA5);
    send(8'h52, 1'b0); send(8'h02, 1'b0);
    expect_resp("read r2", 8'hA5);
    send(8'h57, 1'b0); send(8'h07, 1'b0); send(8'h3C, 1'b0);
    expect_resp("write r7", 8'h4B);
    send(8'h52, 1'b0); send(8'h07, 1'b0);
    expect_resp("read r7", 8'h3C);

    // address range and opcode errors
    send(8'h52, 1'b0); send(8'h08, 1'b0);
    expect_resp("read oob", 8'h3F);
    send(8'h57, 1'b0); send(8'h09, 1'b0);
    expect_resp("write oob", 8'h3F);
    send(8'h11, 1'b0);
    expect_resp("stray byte", 8'h3F);
    check("regs after oob", regs_out, 64'h3C00_0000_00A5_0000);
    send(8'h41, 1'b0);
    expect_resp("bad opcode", 8'h3F);

    // timeout abandons the packet; expiry lands on the 50th idle edge
    send(8'h57, 1'b0); send(8'h03, 1'b0);
    n_tx_seen = 0;
    for (int i = 0; i < 49; i++) begin
      @(negedge clk);
      if (tx_valid) n_tx_seen++;
    end
    check("busy before expiry", 64'(busy), 64'd1);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (tx_valid) n_tx_seen++;
    end
    check("busy after timeout", 64'(busy), 64'd0);
    check("no tx on timeout", 64'(n_tx_seen), 64'd0);
    send(8'h52, 1'b0); send(8'h03, 1'b0);
    expect_resp("read r3", 8'h00);

    // rx_error on the data byte suppresses the write
    send(8'h57, 1'b0); send(8'h01, 1'b0); send(8'h77, 1'b1);
    expect_resp("data error", 8'h3F);
    check("reg1 unchanged", 64'(regs_out[15:8]), 64'h00);

    // backpressure: response held, extra byte dropped
    tx_ready = 1'b0;
    send(8'h52, 1'b0); send(8'h00, 1'b0);
    expect_resp("held read r0", 8'h00);
    repeat (14) @(negedge clk);
    send(8'h57, 1'b0);
    repeat (14) @(negedge clk);
    check("held valid", 64'(tx_valid), 64'd1);
    check("held data", 64'(tx_data), 64'h00);
    tx_ready = 1'b1;
    @(negedge clk);
    check("released", 64'({tx_valid, busy}), 64'd0);
    @(negedge clk);
    check("single transfer", 64'(tx_valid), 64'd0);
    send(8'h52, 1'b0); send(8'h02, 1'b0);
    expect_resp("read after drop", 8'hA5);

    // asynchronous reset mid-packet
    send(8'h57, 1'b0); send(8'h04, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async rst regs", regs_out, 64'd0);
    check("async rst tx_valid", 64'(tx_valid), 64'd0);
    check("async rst busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'h52, 1'b0); send(8'h04, 1'b0);
    expect_resp("read r4 after rst", 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
